// File: rtl/stopwatch_pkg.sv
// Shared definitions for the stopwatch controller: state encoding,
// BCD digit width and the per-digit maximum value.
package stopwatch_pkg;

  localparam int DIGIT_W = 4;
  localparam logic [DIGIT_W-1:0] BCD_MAX = 4'd9;
  localparam int LAP_CNT_W = 4;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'b00,
    ST_RUN   = 2'b01,
    ST_PAUSE = 2'b10,
    ST_LAP   = 2'b11
  } state_t;

  // True in the states where the datapath is allowed to count.
  function automatic logic is_counting(input state_t s);
    return (s == ST_RUN) || (s == ST_LAP);
  endfunction

endpackage

// File: rtl/stopwatch_ctrl_btn_edge.sv
// Button conditioner: SYNC_STAGES-deep synchronizer followed by a registered
// rising-edge detector producing a single-cycle pulse per press.
// The detector is only armed once the synchronizer has been refilled after
// reset and has seen the button low, so a button held through reset release
// never produces a pulse.
module btn_edge #(
  parameter int SYNC_STAGES = 2
) (
  input  logic clk,
  input  logic clr,
  input  logic btn,
  output logic pulse
);

  logic [SYNC_STAGES-1:0] sync_q;
  logic [SYNC_STAGES-1:0] fill_q;
  logic                   prev_q;
  logic                   armed_q;
  logic                   pulse_q;
  logic                   sync_last;

  assign sync_last = sync_q[SYNC_STAGES-1];

  // Synchronizer chain, fill tracker, arming flag and registered edge pulse.
  always_ff @(posedge clk) begin
    if (clr) begin
      sync_q  <= '0;
      fill_q  <= '0;
      prev_q  <= 1'b0;
      armed_q <= 1'b0;
      pulse_q <= 1'b0;
    end else begin
      sync_q  <= {sync_q[SYNC_STAGES-2:0], btn};
      fill_q  <= {fill_q[SYNC_STAGES-2:0], 1'b1};
      prev_q  <= sync_last;
      armed_q <= armed_q | (fill_q[SYNC_STAGES-1] & ~sync_last);
      pulse_q <= armed_q & sync_last & ~prev_q;
    end
  end

  assign pulse = pulse_q;

endmodule

// File: rtl/stopwatch_ctrl.sv
// Stopwatch control FSM: conditions three buttons, sequences
// IDLE/RUN/PAUSE/LAP, gates the datapath count enable, freezes a lap
// snapshot for the display and flags overflow at 9999.
// Handshake: none; go and dp_clr are plain levels sampled by the datapath
// on its rising clk edge.
module stopwatch_ctrl
  import stopwatch_pkg::*;
#(
  parameter int SYNC_STAGES = 2,
  parameter bit STOP_AT_MAX = 1'b1
) (
  input  logic               clk,
  input  logic               clr,
  input  logic               btn_start,
  input  logic               btn_lap,
  input  logic               btn_clear,
  input  logic [DIGIT_W-1:0] cnt_d3,
  input  logic [DIGIT_W-1:0] cnt_d2,
  input  logic [DIGIT_W-1:0] cnt_d1,
  input  logic [DIGIT_W-1:0] cnt_d0,
  output logic               go,
  output logic               dp_clr,
  output logic [DIGIT_W-1:0] disp_d3,
  output logic [DIGIT_W-1:0] disp_d2,
  output logic [DIGIT_W-1:0] disp_d1,
  output logic [DIGIT_W-1:0] disp_d0,
  output logic [1:0]         state,
  output logic               ovf,
  output logic [LAP_CNT_W-1:0] lap_cnt
);

  state_t                 state_q, state_d;
  logic                   ovf_q, ovf_d;
  logic [LAP_CNT_W-1:0]   lap_cnt_q, lap_cnt_d;
  logic [4*DIGIT_W-1:0]   lap_reg_q, lap_reg_d;
  logic                   dp_clr_q, dp_clr_d;
  logic                   p_start, p_lap, p_clear;
  logic                   at_max;
  logic [4*DIGIT_W-1:0]   live;

  btn_edge #(.SYNC_STAGES(SYNC_STAGES)) u_start (.clk(clk), .clr(clr), .btn(btn_start), .pulse(p_start));
  btn_edge #(.SYNC_STAGES(SYNC_STAGES)) u_lap   (.clk(clk), .clr(clr), .btn(btn_lap),   .pulse(p_lap));
  btn_edge #(.SYNC_STAGES(SYNC_STAGES)) u_clear (.clk(clk), .clr(clr), .btn(btn_clear), .pulse(p_clear));

  assign live   = {cnt_d3, cnt_d2, cnt_d1, cnt_d0};
  assign at_max = (cnt_d3 == BCD_MAX) && (cnt_d2 == BCD_MAX) &&
                  (cnt_d1 == BCD_MAX) && (cnt_d0 == BCD_MAX);

  // State and bookkeeping registers.
  always_ff @(posedge clk) begin
    if (clr) begin
      state_q   <= ST_IDLE;
      ovf_q     <= 1'b0;
      lap_cnt_q <= '0;
      lap_reg_q <= '0;
      dp_clr_q  <= 1'b0;
    end else begin
      state_q   <= state_d;
      ovf_q     <= ovf_d;
      lap_cnt_q <= lap_cnt_d;
      lap_reg_q <= lap_reg_d;
      dp_clr_q  <= dp_clr_d;
    end
  end

  // Next-state logic: overflow first, then clear > start > lap.
  always_comb begin
    state_d   = state_q;
    ovf_d     = ovf_q;
    lap_cnt_d = lap_cnt_q;
    lap_reg_d = lap_reg_q;
    dp_clr_d  = 1'b0;
    if (STOP_AT_MAX && at_max && is_counting(state_q)) begin
      state_d = ST_PAUSE;
      ovf_d   = 1'b1;
    end else if (p_clear) begin
      if (state_q == ST_IDLE || state_q == ST_PAUSE) begin
        state_d   = ST_IDLE;
        dp_clr_d  = 1'b1;
        ovf_d     = 1'b0;
        lap_cnt_d = '0;
        lap_reg_d = '0;
      end
    end else if (p_start) begin
      case (state_q)
        ST_IDLE:  state_d = ST_RUN;
        ST_RUN:   state_d = ST_PAUSE;
        ST_PAUSE: if (!ovf_q) state_d = ST_RUN;
        ST_LAP:   state_d = ST_PAUSE;
        default:  state_d = ST_IDLE;
      endcase
    end else if (p_lap) begin
      if (state_q == ST_RUN) begin
        state_d   = ST_LAP;
        lap_reg_d = live;
        if (lap_cnt_q != {LAP_CNT_W{1'b1}}) lap_cnt_d = lap_cnt_q + 1'b1;
      end else if (state_q == ST_LAP) begin
        state_d = ST_RUN;
      end
    end
  end

  // Outputs: reset overrides go/dp_clr; display shows the lap snapshot in LAP.
  always_comb begin
    go      = ~clr & is_counting(state_q) & ~(STOP_AT_MAX & at_max);
    dp_clr  = clr | dp_clr_q;
    {disp_d3, disp_d2, disp_d1, disp_d0} = (state_q == ST_LAP) ? lap_reg_q : live;
    state   = state_q;
    ovf     = ovf_q;
    lap_cnt = lap_cnt_q;
  end

endmodule

// File: tb/tb_stopwatch_ctrl.sv
// Directed bench for stopwatch_ctrl. A second instance with STOP_AT_MAX=0
// shares all inputs to cover the wrapping configuration.
module tb_stopwatch_ctrl;

  logic       clk = 1'b0;
  logic       clr;
  logic       btn_start, btn_lap, btn_clear;
  logic [3:0] cnt_d3, cnt_d2, cnt_d1, cnt_d0;
  logic       go, dp_clr, ovf;
  logic [3:0] disp_d3, disp_d2, disp_d1, disp_d0;
  logic [1:0] state;
  logic [3:0] lap_cnt;
  logic       w_go, w_dp_clr, w_ovf;
  logic [3:0] w_disp_d3, w_disp_d2, w_disp_d1, w_disp_d0;
  logic [1:0] w_state;
  logic [3:0] w_lap_cnt;

  int checks = 0;
  int errors = 0;

  // Clock / reset block
  always #5 clk = ~clk;

  stopwatch_ctrl #(.SYNC_STAGES(2), .STOP_AT_MAX(1'b1)) dut (
    .clk(clk), .clr(clr), .btn_start(btn_start), .btn_lap(btn_lap), .btn_clear(btn_clear),
    .cnt_d3(cnt_d3), .cnt_d2(cnt_d2), .cnt_d1(cnt_d1), .cnt_d0(cnt_d0),
    .go(go), .dp_clr(dp_clr),
    .disp_d3(disp_d3), .disp_d2(disp_d2), .disp_d1(disp_d1), .disp_d0(disp_d0),
    .state(state), .ovf(ovf), .lap_cnt(lap_cnt)
  );

  stopwatch_ctrl #(.SYNC_STAGES(2), .STOP_AT_MAX(1'b0)) u_wrap (
    .clk(clk), .clr(clr), .btn_start(btn_start), .btn_lap(btn_lap), .btn_clear(btn_clear),
    .cnt_d3(cnt_d3), .cnt_d2(cnt_d2), .cnt_d1(cnt_d1), .cnt_d0(cnt_d0),
    .go(w_go), .dp_clr(w_dp_clr),
    .disp_d3(w_disp_d3), .disp_d2(w_disp_d2), .disp_d1(w_disp_d1), .disp_d0(w_disp_d0),
    .state(w_state), .ovf(w_ovf), .lap_cnt(w_lap_cnt)
  );

  // Driver tasks
  task automatic tick(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic set_cnt(input logic [15:0] v);
    {cnt_d3, cnt_d2, cnt_d1, cnt_d0} = v;
  endtask

  // which: 0 = start, 1 = lap, 2 = clear; hold 10 cycles then release
  task automatic press_full(input int which);
    if (which == 0) btn_start = 1'b1;
    else if (which == 1) btn_lap = 1'b1;
    else btn_clear = 1'b1;
    tick(10);
    btn_start = 1'b0;
    btn_lap   = 1'b0;
    btn_clear = 1'b0;
    tick(4);
  endtask

  // Scoreboard check
  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  function automatic logic [15:0] disp_v();
    return {disp_d3, disp_d2, disp_d1, disp_d0};
  endfunction

  initial begin
    clr = 1'b1;
    btn_start = 1'b0;
    btn_lap   = 1'b0;
    btn_clear = 1'b0;
    set_cnt(16'h0000);
    tick(2);
    chk("rst_state",  16'(state), 16'h0);
    chk("rst_ovf",    16'(ovf), 16'h0);
    chk("rst_lapcnt", 16'(lap_cnt), 16'h0);
    chk("rst_dpclr",  16'(dp_clr), 16'h1);
    chk("rst_go",     16'(go), 16'h0);
    clr = 1'b0;
    tick(5);
    chk("post_rst_dpclr", 16'(dp_clr), 16'h0);

    // start held 10 cycles: visible at the 4th edge, one transition only
    btn_start = 1'b1;
    tick(3);
    chk("start_edge3", 16'(state), 16'h0);
    tick(1);
    chk("start_edge4", 16'(state), 16'h1);
    chk("start_go",    16'(go), 16'h1);
    tick(6);
    chk("start_held",  16'(state), 16'h1);
    btn_start = 1'b0;
    tick(4);

    // lap freeze and release
    set_cnt(16'h0123);
    btn_lap = 1'b1;
    tick(4);
    chk("lap_state",  16'(state), 16'h3);
    chk("lap_disp",   disp_v(), 16'h0123);
    chk("lap_cnt1",   16'(lap_cnt), 16'h1);
    set_cnt(16'h0150);
    #1;
    chk("lap_frozen", disp_v(), 16'h0123);
    chk("lap_go",     16'(go), 16'h1);
    tick(6);
    btn_lap = 1'b0;
    tick(4);
    btn_lap = 1'b1;
    tick(4);
    chk("lap2_state", 16'(state), 16'h1);
    chk("lap2_disp",  disp_v(), 16'h0150);
    set_cnt(16'h0151);
    #1;
    chk("lap2_live",  disp_v(), 16'h0151);
    chk("lap2_cnt",   16'(lap_cnt), 16'h1);
    tick(6);
    btn_lap = 1'b0;
    tick(4);

    // overflow at 9999
    set_cnt(16'h9999);
    #1;
    chk("max_go",      16'(go), 16'h0);
    chk("wrap_max_go", 16'(w_go), 16'h1);
    tick(1);
    chk("ovf_state",   16'(state), 16'h2);
    chk("ovf_flag",    16'(ovf), 16'h1);
    chk("wrap_state",  16'(w_state), 16'h1);
    chk("wrap_ovf",    16'(w_ovf), 16'h0);
    press_full(0);
    chk("ovf_start_ign", 16'(state), 16'h2);
    chk("ovf_hold",      16'(ovf), 16'h1);
    set_cnt(16'h0000);
    btn_clear = 1'b1;
    tick(3);
    chk("clr_edge3",  16'(state), 16'h2);
    tick(1);
    chk("clr_state",  16'(state), 16'h0);
    chk("clr_dpclr",  16'(dp_clr), 16'h1);
    chk("clr_ovf",    16'(ovf), 16'h0);
    tick(1);
    chk("clr_dpclr_end", 16'(dp_clr), 16'h0);
    tick(5);
    btn_clear = 1'b0;
    tick(4);

    // clear and start together in PAUSE
    press_full(0);
    press_full(0);
    chk("pause_setup", 16'(state), 16'h2);
    btn_clear = 1'b1;
    btn_start = 1'b1;
    tick(4);
    chk("both_state", 16'(state), 16'h0);
    chk("both_dpclr", 16'(dp_clr), 16'h1);
    tick(6);
    chk("both_norun", 16'(state), 16'h0);
    btn_clear = 1'b0;
    btn_start = 1'b0;
    tick(4);

    // clear ignored in RUN, clr in LAP
    press_full(0);
    chk("run_again", 16'(state), 16'h1);
    press_full(2);
    chk("run_clear_ign", 16'(state), 16'h1);
    chk("run_clear_dp",  16'(dp_clr), 16'h0);
    press_full(1);
    chk("lap_again",  16'(state), 16'h3);
    chk("lap_again_cnt", 16'(lap_cnt), 16'h1);
    clr = 1'b1;
    tick(1);
    chk("clr_lap_state", 16'(state), 16'h0);
    chk("clr_lap_cnt",   16'(lap_cnt), 16'h0);
    chk("clr_lap_dpclr", 16'(dp_clr), 16'h1);
    chk("clr_lap_go",    16'(go), 16'h0);
    // start held across reset release must not start the watch
    btn_start = 1'b1;
    tick(2);
    clr = 1'b0;
    tick(12);
    chk("held_thru_clr", 16'(state), 16'h0);
    btn_start = 1'b0;
    tick(5);
    press_full(0);
    chk("rearmed_start", 16'(state), 16'h1);

    // lap counter saturation
    for (int i = 0; i < 17; i++) begin
      press_full(1);
      press_full(1);
      if (i == 13) chk("lap_cnt14", 16'(lap_cnt), 16'd14);
    end
    chk("lap_cnt_sat", 16'(lap_cnt), 16'd15);
    chk("sat_state",   16'(state), 16'h1);

    // overflow exit from LAP beats a same-cycle lap pulse
    press_full(1);
    chk("lap3_state", 16'(state), 16'h3);
    btn_lap = 1'b1;
    tick(3);
    set_cnt(16'h9999);
    tick(1);
    chk("lap_ovf_state", 16'(state), 16'h2);
    chk("lap_ovf_flag",  16'(ovf), 16'h1);
    chk("lap_ovf_disp",  disp_v(), 16'h9999);
    btn_lap = 1'b0;
    tick(4);

    // Final report
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/stopwatch_ctrl.md
STOPWATCH_CTRL -- requirements
Module: stopwatch_ctrl

Interface
REQ-001 SHALL have parameter SYNC_STAGES, default 2: synchronizer flops per button, minimum 2.
REQ-002 SHALL have parameter STOP_AT_MAX, default 1: 1 = halt at 9999, 0 = let the datapath wrap to 0000.
REQ-003 SHALL have port clk, input, 1: single clock; all logic on its rising edge.
REQ-004 SHALL have port clr, input, 1: reset, synchronous and active-high.
REQ-005 SHALL have port btn_start, input, 1: asynchronous level, start/stop toggle.
REQ-006 SHALL have port btn_lap, input, 1: asynchronous level, lap freeze/release.
REQ-007 SHALL have port btn_clear, input, 1: asynchronous level, clear request.
REQ-008 SHALL have ports cnt_d3, cnt_d2, cnt_d1, cnt_d0, input, 4 each: live BCD digits from the counter datapath.
REQ-009 SHALL have port go, output, 1: count enable to the datapath.
REQ-010 SHALL have port dp_clr, output, 1: clear to the datapath.
REQ-011 SHALL have ports disp_d3, disp_d2, disp_d1, disp_d0, output, 4 each: digits to the display.
REQ-012 SHALL have port state, output, 2: IDLE=00, RUN=01, PAUSE=10, LAP=11.
REQ-013 SHALL have port ovf, output, 1: sticky overflow flag.
REQ-014 SHALL have port lap_cnt, output, 4: number of laps taken, saturating.

Function
REQ-015 SHALL pass each button through SYNC_STAGES flops, then a rising-edge detector giving a 1-cycle pulse; a held button gives one pulse only.
REQ-016 SHALL make the state change visible SYNC_STAGES+2 edges after the first edge that samples the button high.
REQ-017 SHALL apply same-cycle pulse priority: clear over start over lap; lower-priority pulses in that cycle are dropped.
REQ-018 SHALL implement these transitions: IDLE+start->RUN; RUN+start->PAUSE; PAUSE+start->RUN unless ovf=1; RUN+lap->LAP; LAP+lap->RUN; LAP+start->PAUSE.
REQ-019 SHALL, on clear in IDLE or PAUSE, go to IDLE, drive dp_clr=1 for exactly one cycle, zero ovf, lap_cnt and the lap register.
REQ-020 SHALL ignore clear in RUN or LAP.
REQ-021 SHALL ignore lap in IDLE or PAUSE; all other unlisted pulse/state pairs leave state unchanged.
REQ-022 SHALL compute at_max as cnt digits == 9,9,9,9.
REQ-023 SHALL drive go combinationally = (state==RUN or state==LAP) and not (STOP_AT_MAX and at_max).
REQ-024 SHALL, when STOP_AT_MAX=1 and at_max in RUN or LAP, set ovf and enter PAUSE at the next edge; ovf holds until clear or clr.
REQ-025 SHALL, with STOP_AT_MAX=0, never set ovf; go is unaffected by at_max.
REQ-026 SHALL, on the RUN->LAP edge, capture cnt_d3..d0 into a 16-bit lap register and increment lap_cnt, saturating at 15.
REQ-027 SHALL drive disp = lap register in LAP and cnt digits in every other state, combinationally.
REQ-028 SHALL give an overflow exit from LAP precedence over a same-cycle lap pulse; the display returns to live digits.

Reset
REQ-029 SHALL, while clr=1 at an edge: state=IDLE, ovf=0, lap_cnt=0, lap register=0, synchronizer and edge flops=0.
REQ-030 SHALL hold dp_clr=1 and go=0 combinationally while clr=1, overriding all state.
REQ-031 SHALL not generate a start pulse from a button held through the release of clr.
REQ-032 SHALL accept mid-operation reset: clr in RUN or LAP returns to IDLE on the next edge with no residual pulse.

Structure
REQ-033 SHALL take from shared package stopwatch_pkg: the state encoding constants, the BCD_MAX digit constant (9) and the digit width (4).
REQ-034 SHALL use one sub-module, btn_edge (synchronizer plus rising-edge pulse, parameter SYNC_STAGES), instantiated three times.

Verification
REQ-035 SHALL cover: clr, then start held 10 cycles -> state=01 at edge SYNC_STAGES+2, exactly one transition, go=1.
REQ-036 SHALL cover: RUN with digits 0123, lap pulse -> state=11, disp=0123 while live advances to 0150; second lap -> disp follows live; lap_cnt=1.
REQ-037 SHALL cover: STOP_AT_MAX=1, RUN, digits reach 9999 -> go=0 the same cycle, next edge state=10, ovf=1; start ignored; clear -> IDLE, dp_clr one cycle, ovf=0.
REQ-038 SHALL cover: clear and start rising on the same cycle in PAUSE -> IDLE, dp_clr pulse, no RUN.
REQ-039 SHALL cover: clear in RUN -> ignored; clr asserted in LAP -> state=00, lap_cnt=0, dp_clr=1 while clr high.
REQ-040 SHALL cover: 17 lap/lap cycle pairs from RUN -> lap_cnt saturates at 15.
